multicycle_ctrl: RTL

Multi-cycle control unit for the 32-bit, 16-register core. It sequences every instruction through fetch, decode, execute, memory and writeback. It classifies the 6-bit opcode and 2-bit mode delivered by the instruction register, and drives the PC, IR, register-file, ALU, stack-pointer and shared instruction/data memory controls. One memory port is shared by fetch and data accesses through a ready handshake.

---
 rtl/multicycle_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback
// and drives PC, IR, register-file, ALU, SP and shared memory controls.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [1:0] mode,
   input  logic       cmp_eq,
   input  logic       cmp_gt,
   input  logic       cmp_lt,
   input  logic       mem_ready,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] pc_src,
   output logic [1:0] addr_sel,
   output logic       mem_req,
   output logic       mem_we,
   output logic       data_sel,
   output logic       src2_sel,
   output logic       alu_src,
   output logic       ext_sel,
   output logic [1:0] alu_op,
   output logic       wb_sel,
   output logic       dst_sel,
   output logic [1:0] sp_op,
   output logic       illegal,
   output logic [2:0] state
);

   localparam int unsigned OPW = 6;

   localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
   localparam logic [OPW-1:0] OP_ANDI = OPW'(3);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(4);
   localparam logic [OPW-1:0] OP_LW   = OPW'(5);
   localparam logic [OPW-1:0] OP_SW   = OPW'(6);
   localparam logic [OPW-1:0] OP_BGT  = OPW'(7);
   localparam logic [OPW-1:0] OP_BLT  = OPW'(8);
   localparam logic [OPW-1:0] OP_BEQ  = OPW'(9);
   localparam logic [OPW-1:0] OP_BNE  = OPW'(10);
   localparam logic [OPW-1:0] OP_JMP  = OPW'(12);
   localparam logic [OPW-1:0] OP_CALL = OPW'(13);
   localparam logic [OPW-1:0] OP_RET  = OPW'(14);
   localparam logic [OPW-1:0] OP_PUSH = OPW'(15);
   localparam logic [OPW-1:0] OP_POP  = OPW'(16);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_WB2    = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   state_t cur, nxt;

   // Instruction classification from the IR fields
   logic is_r, is_andi, is_addi, is_lw, is_sw, is_br, is_jmp;
   logic is_call, is_ret, is_push, is_pop, is_arith, is_legal, br_taken;
   logic [1:0] arith_op;

   always_comb begin
      is_r     = (opcode <= OP_SUB);
      is_andi  = (opcode == OP_ANDI);
      is_addi  = (opcode == OP_ADDI);
      is_lw    = (opcode == OP_LW);
      is_sw    = (opcode == OP_SW);
      is_br    = (opcode >= OP_BGT) && (opcode <= OP_BNE);
      is_jmp   = (opcode == OP_JMP);
      is_call  = (opcode == OP_CALL);
      is_ret   = (opcode == OP_RET);
      is_push  = (opcode == OP_PUSH);
      is_pop   = (opcode == OP_POP);
      is_arith = is_r || is_andi || is_addi;
      is_legal = ((opcode <= OP_BNE) || ((opcode >= OP_JMP) && (opcode <= OP_POP)))
                 && !(is_lw && mode[1]);
      arith_op = is_r ? opcode[1:0] : (is_addi ? 2'b01 : 2'b00);
      case (opcode)
         OP_BGT:  br_taken = cmp_gt;
         OP_BLT:  br_taken = cmp_lt;
         OP_BEQ:  br_taken = cmp_eq;
         default: br_taken = !cmp_eq;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur     <= S_INIT;
         illegal <= 1'b0;
      end else begin
         cur <= nxt;
         if ((cur == S_DECODE) && (nxt == S_HALT)) illegal <= 1'b1;
      end
   end

   assign state = 3'(cur);

   always_comb begin
      nxt       = cur;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      pc_src    = 2'b00;
      addr_sel  = 2'b00;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      data_sel  = 1'b0;
      src2_sel  = 1'b0;
      alu_src   = 1'b0;
      ext_sel   = 1'b0;
      alu_op    = 2'b00;
      wb_sel    = 1'b0;
      dst_sel   = 1'b0;
      sp_op     = 2'b00;
      case (cur)
         S_INIT: nxt = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               nxt      = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!is_legal) nxt = S_HALT;
            else if (is_jmp) begin
               pc_write = 1'b1;
               pc_src   = 2'b10;
               nxt      = S_FETCH;
            end else if (is_call || is_push) nxt = S_MEM;
            else nxt = S_EXEC;
         end
         S_EXEC: begin
            nxt = S_FETCH;
            if (is_arith) begin
               alu_op  = arith_op;
               alu_src = is_andi || is_addi;
               ext_sel = is_addi;
               nxt     = S_WB;
            end else if (is_lw || is_sw) begin
               alu_op  = 2'b01;
               alu_src = 1'b1;
               ext_sel = 1'b1;
               nxt     = S_MEM;
            end else if (is_br) begin
               alu_op   = 2'b10;
               src2_sel = 1'b1;
               ext_sel  = 1'b1;
               pc_write = br_taken;
               pc_src   = br_taken ? 2'b01 : 2'b00;
            end else if (is_ret || is_pop) begin
               sp_op = 2'b01;
               nxt   = S_MEM;
            end
         end
         S_MEM: begin
            // Request attributes are held constant until the completing edge
            mem_req  = 1'b1;
            addr_sel = (is_lw || is_sw) ? 2'b01 : 2'b10;
            mem_we   = is_sw || is_call || is_push;
            data_sel = is_call;
            src2_sel = is_sw;
            if (mem_ready) begin
               nxt = (is_lw || is_pop) ? S_WB : S_FETCH;
               if (is_call || is_push) sp_op = 2'b10;
               if (is_call) begin
                  pc_write = 1'b1;
                  pc_src   = 2'b10;
               end else if (is_ret) begin
                  pc_write = 1'b1;
                  pc_src   = 2'b11;
               end
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            wb_sel    = is_lw || is_pop;
            if (is_arith) begin
               alu_op  = arith_op;
               alu_src = is_andi || is_addi;
               ext_sel = is_addi;
            end
            nxt = (is_lw && (mode == 2'b01)) ? S_WB2 : S_FETCH;
         end
         S_WB2: begin
            // Post-increment of the base register; datapath forces imm to +1
            reg_write = 1'b1;
            dst_sel   = 1'b1;
            alu_op    = 2'b01;
            alu_src   = 1'b1;
            nxt       = S_FETCH;
         end
         S_HALT: nxt = S_HALT;
         default: nxt = S_INIT;
      endcase
   end

endmodule
